imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Decode-stage immediate sequencer for the pipelined RV32I core.
- Takes fetched instructions over a valid/ready handshake and selects the extension mode (EXTOp).
- Extracts the immediate fields, instantiates and drives the immediate extender, and delivers registered immediates to the execute stage.
- Two-stage internal pipeline (S1 decode/field capture, S2 extended-immediate register) with backpressure and flush.

Parameters:
- PC_W, 32, width of the pc carried alongside each instruction.
- DROP_ILLEGAL, 0, 1 = illegal-opcode instructions are consumed but never raise out_valid; 0 = forwarded with out_illegal=1.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  pc of in_instr.
- flush  in  1  synchronous kill of all in-flight entries.
- out_valid  out  1  S2 holds a result.
- out_ready  in  1  execute stage accepts.
- out_imm  out  32  extended immediate.
- out_extop  out  6  EXTOp used.
- out_illegal  out  1  opcode not recognised.
- out_pc  out  PC_W  pc of the result.
- out_target  out  PC_W  pc+imm; present only with IMM_TARGET_EN.

Behaviour:
- Reset (async, rst=1): S1/S2 valid=0; out_imm, out_extop, out_illegal, out_pc and out_target are all 0; in_ready=1 after release.
- EXTOp one-hot encoding: SHAMT 6'b100000, ITYPE 6'b010000, STYPE 6'b001000, BTYPE 6'b000100, UTYPE 6'b000010, JTYPE 6'b000001, none 6'b000000.
- Opcode decode (instr[6:0]):
  - 0010011 with funct3 001/101 -> SHAMT; other funct3 -> ITYPE.
  - 0000011 and 1100111 -> ITYPE.
  - 0100011 -> STYPE.
  - 1100011 -> BTYPE.
  - 0110111 and 0010111 -> UTYPE.
  - 1101111 -> JTYPE.
  - 0110011 -> none, legal, imm 0.
  - any other opcode -> none, illegal=1, imm 0.
- Field slicing into the extender:
  - shamt = instr[24:20]
  - iimm = instr[31:20]
  - simm = {instr[31:25], instr[11:7]}
  - bimm = {instr[31], instr[7], instr[30:25], instr[11:8]}
  - uimm = instr[31:12]
  - jimm = {instr[31], instr[19:12], instr[20], instr[30:21]}
- S1 captures EXTOp, the fields, pc and the illegal flag on acceptance (in_valid & in_ready). S2 captures the extender output from S1.
- Latency: accepted at edge N -> out_valid at edge N+2 when unstalled. Throughput 1/cycle.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational, no dependency on in_valid)
- Stall: with out_ready=0, S2 holds its value stable. S1 fills if empty; in_ready drops once both stages are full. Order is strictly preserved and nothing is lost or duplicated.
- Flush: both valids clear at the next edge. An instruction presented in the flush cycle is discarded even if in_ready=1. Flush takes priority over acceptance and advance. Data registers need not clear.
- DROP_ILLEGAL=1: an illegal entry clears its valid on the S1->S2 move.
- Reset asserted mid-operation: immediate return to reset values; no partial result is emitted after release.
- Arithmetic: sign extension from bit 11 (I/S), bit 12 (B, LSB 0) and bit 20 (J, LSB 0). U = uimm<<12. SHAMT zero-extended.

Optional Feature:
- Macro IMM_TARGET_EN.
- Defined: S2 also registers out_target = out_pc + out_imm (mod 2^PC_W) for BTYPE/JTYPE/UTYPE entries, and out_pc for all others. Reset value 0.
- Undefined: no out_target port and no adder; all other behaviour is identical.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), pc 0x0 -> two cycles later out_extop=6'b010000, out_imm=0xFFFFFFFF, out_illegal=0.
- 0x01F09093 (slli x1,x1,31) -> out_extop=6'b100000, out_imm=0x0000001F. Then 0x123452B7 (lui x5,0x12345) -> out_extop=6'b000010, out_imm=0x12345000.
- 0xFE000EE3 (beq x0,x0,-4) at pc 0x200 -> out_extop=6'b000100, out_imm=0xFFFFFFFC. With IMM_TARGET_EN: out_target=0x1FC. Also 0x0080006F (jal +8) at pc 0x100 -> imm 0x8, target 0x108.
- Back-to-back stream of 4 instructions with out_ready held low for 3 cycles -> in_ready low after 2 accepted, out values stable while stalled, all 4 delivered in order, no duplicates.
- flush pulsed with both stages full plus in_valid=1 -> next cycle out_valid=0, the presented instruction is not accepted, in_ready=1. Then rst pulsed mid-stream -> all outputs 0 at once.
- 0xFFFFFFFF (illegal opcode) -> with DROP_ILLEGAL=0: out_illegal=1, out_extop=0, out_imm=0. With DROP_ILLEGAL=1: out_valid never rises for it.

Source files
------------

// File: rtl/imm_decode_stage.sv
// imm_decode_stage -- decode-stage immediate sequencer for the pipelined RV32I core.
//
// Accepts instruction words over a valid/ready handshake and decodes the opcode
// into a one-hot EXTOp. In the same cycle it slices out the immediate fields.
// S1 registers the fields. The imm_extender (also in this file) turns them into a
// 32-bit immediate, which S2 registers for the execute stage. Both stages stall
// under backpressure, and a flush kills both of them.
//
// Optional build macro: IMM_TARGET_EN
//   When defined, S2 also registers out_target:
//     - pc + imm for B/J/U entries,
//     - pc for every other entry.
//   When undefined, the out_target port and its adder do not exist.
//
// Parameters:
//   PC_W          width of the pc carried with each instruction
//   DROP_ILLEGAL  1: illegal-opcode entries are consumed silently;
//                 0: they are forwarded with out_illegal=1
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          instruction handshake
//   in_instr/in_pc             instruction word and its pc
//   flush                      synchronous kill of all in-flight entries
//   out_valid/out_ready        result handshake
//   out_imm, out_extop         extended immediate and the EXTOp used
//   out_illegal                opcode not recognised
//   out_pc, out_target         pc of the result, branch/jump target

// Combinational immediate extender driven by a one-hot EXTOp.
module imm_extender (
  input  logic [5:0]  i_extop,
  input  logic [4:0]  i_shamt,
  input  logic [11:0] i_iimm,
  input  logic [11:0] i_simm,
  input  logic [11:0] i_bimm,
  input  logic [19:0] i_uimm,
  input  logic [19:0] i_jimm,
  output logic [31:0] o_imm
);
  always_comb begin
    o_imm = '0;
    case (i_extop)
      6'b100000: o_imm = {27'b0, i_shamt};
      6'b010000: o_imm = {{20{i_iimm[11]}}, i_iimm};
      6'b001000: o_imm = {{20{i_simm[11]}}, i_simm};
      6'b000100: o_imm = {{19{i_bimm[11]}}, i_bimm, 1'b0};
      6'b000010: o_imm = {i_uimm, 12'b0};
      6'b000001: o_imm = {{11{i_jimm[19]}}, i_jimm, 1'b0};
      default:   o_imm = '0;
    endcase
  end
endmodule

module imm_decode_stage #(
  parameter int PC_W         = 32,
  parameter int DROP_ILLEGAL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_imm,
  output logic [5:0]      out_extop,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
`ifdef IMM_TARGET_EN
  , output logic [PC_W-1:0] out_target
`endif
);

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_ITYPE = 6'b010000;
  localparam logic [5:0] EXT_STYPE = 6'b001000;
  localparam logic [5:0] EXT_BTYPE = 6'b000100;
  localparam logic [5:0] EXT_UTYPE = 6'b000010;
  localparam logic [5:0] EXT_JTYPE = 6'b000001;
  localparam logic [5:0] EXT_NONE  = 6'b000000;

  // Handshake / advance control
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_accept;
  logic w_s1_drop;

  // Decode of the incoming word
  logic [5:0] w_extop;
  logic       w_illegal;

  // S1 registers
  logic            r_s1_valid;
  logic [5:0]      r_s1_extop;
  logic            r_s1_illegal;
  logic [PC_W-1:0] r_s1_pc;
  logic [4:0]      r_s1_shamt;
  logic [11:0]     r_s1_iimm;
  logic [11:0]     r_s1_simm;
  logic [11:0]     r_s1_bimm;
  logic [19:0]     r_s1_uimm;
  logic [19:0]     r_s1_jimm;

  // S2 registers
  logic            r_s2_valid;
  logic [31:0]     r_s2_imm;
  logic [5:0]      r_s2_extop;
  logic            r_s2_illegal;
  logic [PC_W-1:0] r_s2_pc;

  logic [31:0] w_imm;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_accept = in_valid && w_s1_adv;
  assign w_s1_drop = (DROP_ILLEGAL != 0) && r_s1_illegal;

  always_comb begin
    w_extop   = EXT_NONE;
    w_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0010011: w_extop = (in_instr[13:12] == 2'b01) ? EXT_SHAMT : EXT_ITYPE;
      7'b0000011,
      7'b1100111: w_extop = EXT_ITYPE;
      7'b0100011: w_extop = EXT_STYPE;
      7'b1100011: w_extop = EXT_BTYPE;
      7'b0110111,
      7'b0010111: w_extop = EXT_UTYPE;
      7'b1101111: w_extop = EXT_JTYPE;
      7'b0110011: w_extop = EXT_NONE;
      default:    w_illegal = 1'b1;
    endcase
  end

  // ---- S1: decode / field capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_extop   <= '0;
      r_s1_illegal <= 1'b0;
      r_s1_pc      <= '0;
      r_s1_shamt   <= '0;
      r_s1_iimm    <= '0;
      r_s1_simm    <= '0;
      r_s1_bimm    <= '0;
      r_s1_uimm    <= '0;
      r_s1_jimm    <= '0;
    end else begin
      if (flush)
        r_s1_valid <= 1'b0;
      else if (w_s1_adv)
        r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_extop   <= w_extop;
        r_s1_illegal <= w_illegal;
        r_s1_pc      <= in_pc;
        r_s1_shamt   <= in_instr[24:20];
        r_s1_iimm    <= in_instr[31:20];
        r_s1_simm    <= {in_instr[31:25], in_instr[11:7]};
        r_s1_bimm    <= {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
        r_s1_uimm    <= in_instr[31:12];
        r_s1_jimm    <= {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
      end
    end
  end

  imm_extender u_ext (
    .i_extop (r_s1_extop),
    .i_shamt (r_s1_shamt),
    .i_iimm  (r_s1_iimm),
    .i_simm  (r_s1_simm),
    .i_bimm  (r_s1_bimm),
    .i_uimm  (r_s1_uimm),
    .i_jimm  (r_s1_jimm),
    .o_imm   (w_imm)
  );

  // ---- S2: extended-immediate register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_imm     <= '0;
      r_s2_extop   <= '0;
      r_s2_illegal <= 1'b0;
      r_s2_pc      <= '0;
    end else begin
      if (flush)
        r_s2_valid <= 1'b0;
      else if (w_s2_adv)
        r_s2_valid <= r_s1_valid && !w_s1_drop;
      if (w_s2_adv && r_s1_valid) begin
        r_s2_imm     <= w_imm;
        r_s2_extop   <= r_s1_extop;
        r_s2_illegal <= r_s1_illegal;
        r_s2_pc      <= r_s1_pc;
      end
    end
  end

`ifdef IMM_TARGET_EN
  logic [PC_W-1:0] r_s2_target;
  logic [PC_W-1:0] w_target;
  // The immediate is sign-extended or truncated to the pc width; the add wraps.
  always_comb begin
    w_target = r_s1_pc;
    if (r_s1_extop == EXT_BTYPE || r_s1_extop == EXT_JTYPE || r_s1_extop == EXT_UTYPE)
      w_target = r_s1_pc + PC_W'($signed(w_imm));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_s2_target <= '0;
    else if (w_s2_adv && r_s1_valid)
      r_s2_target <= w_target;
  end
  assign out_target = r_s2_target;
`endif

  assign out_valid   = r_s2_valid;
  assign out_imm     = r_s2_imm;
  assign out_extop   = r_s2_extop;
  assign out_illegal = r_s2_illegal;
  assign out_pc      = r_s2_pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage.
// Contents:
//   - a vector table of single instructions,
//   - hand-written stall, flush, reset and drop-illegal sequences.
// dut uses DROP_ILLEGAL=0 and dut_d uses DROP_ILLEGAL=1; the two share every input.
module tb_imm_decode_stage;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_ready;

  logic            in_ready, out_valid, out_illegal;
  logic [31:0]     out_imm;
  logic [5:0]      out_extop;
  logic [PC_W-1:0] out_pc;

  logic            d_in_ready, d_out_valid, d_out_illegal;
  logic [31:0]     d_out_imm;
  logic [5:0]      d_out_extop;
  logic [PC_W-1:0] d_out_pc;
`ifdef IMM_TARGET_EN
  logic [PC_W-1:0] out_target, d_out_target;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.PC_W(PC_W), .DROP_ILLEGAL(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_extop(out_extop), .out_illegal(out_illegal), .out_pc(out_pc)
`ifdef IMM_TARGET_EN
    , .out_target(out_target)
`endif
  );

  imm_decode_stage #(.PC_W(PC_W), .DROP_ILLEGAL(1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_imm(d_out_imm),
    .out_extop(d_out_extop), .out_illegal(d_out_illegal), .out_pc(d_out_pc)
`ifdef IMM_TARGET_EN
    , .out_target(d_out_target)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  extop;
    logic [31:0] imm;
    logic        ill;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] s_instr[4];
    logic [31:0] s_imm[4];
    logic [31:0] outs[4];
    int acc, got, dcnt;
    logic [31:0] dpc;

    vecs[0]  = '{32'hFFF00093, 32'h000, 6'b010000, 32'hFFFFFFFF, 1'b0, 32'h000};
    vecs[1]  = '{32'h01F09093, 32'h004, 6'b100000, 32'h0000001F, 1'b0, 32'h004};
    vecs[2]  = '{32'h123452B7, 32'h008, 6'b000010, 32'h12345000, 1'b0, 32'h12345008};
    vecs[3]  = '{32'hFE000EE3, 32'h200, 6'b000100, 32'hFFFFFFFC, 1'b0, 32'h1FC};
    vecs[4]  = '{32'h0080006F, 32'h100, 6'b000001, 32'h00000008, 1'b0, 32'h108};
    vecs[5]  = '{32'hFE112E23, 32'h010, 6'b001000, 32'hFFFFFFFC, 1'b0, 32'h010};
    vecs[6]  = '{32'h00001517, 32'h040, 6'b000010, 32'h00001000, 1'b0, 32'h1040};
    vecs[7]  = '{32'h4050D093, 32'h044, 6'b100000, 32'h00000005, 1'b0, 32'h044};
    vecs[8]  = '{32'h00008067, 32'h048, 6'b010000, 32'h00000000, 1'b0, 32'h048};
    vecs[9]  = '{32'h002081B3, 32'h04C, 6'b000000, 32'h00000000, 1'b0, 32'h04C};
    vecs[10] = '{32'hFFFFFFFF, 32'h050, 6'b000000, 32'h00000000, 1'b1, 32'h050};
    vecs[11] = '{32'h80002083, 32'h054, 6'b010000, 32'hFFFFF800, 1'b0, 32'h054};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst out_imm", {32'b0, out_imm}, 64'd0);
    chk("rst out_extop", {58'b0, out_extop}, 64'd0);
    chk("rst out_illegal", {63'b0, out_illegal}, 64'd0);
    chk("rst out_pc", {32'b0, out_pc}, 64'd0);
`ifdef IMM_TARGET_EN
    chk("rst out_target", {32'b0, out_target}, 64'd0);
`endif
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst in_ready", {63'b0, in_ready}, 64'd1);

    // Table of single instructions: accepted at one edge, visible after the next
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d early valid", i), {63'b0, out_valid}, 64'd0);
      tick();
      chk($sformatf("vec%0d valid", i), {63'b0, out_valid}, 64'd1);
      chk($sformatf("vec%0d imm", i), {32'b0, out_imm}, {32'b0, vecs[i].imm});
      chk($sformatf("vec%0d extop", i), {58'b0, out_extop}, {58'b0, vecs[i].extop});
      chk($sformatf("vec%0d illegal", i), {63'b0, out_illegal}, {63'b0, vecs[i].ill});
      chk($sformatf("vec%0d pc", i), {32'b0, out_pc}, {32'b0, vecs[i].pc});
`ifdef IMM_TARGET_EN
      chk($sformatf("vec%0d target", i), {32'b0, out_target}, {32'b0, vecs[i].tgt});
`endif
    end
    tick();
    chk("drain valid", {63'b0, out_valid}, 64'd0);

    // Back-to-back stream with backpressure
    s_instr[0] = 32'hFFF00093; s_imm[0] = 32'hFFFFFFFF;
    s_instr[1] = 32'h01F09093; s_imm[1] = 32'h0000001F;
    s_instr[2] = 32'h123452B7; s_imm[2] = 32'h12345000;
    s_instr[3] = 32'hFE000EE3; s_imm[3] = 32'hFFFFFFFC;
    acc = 0; got = 0;
    for (int c = 0; c < 25; c++) begin
      in_valid  = (acc < 4);
      in_instr  = s_instr[(acc < 4) ? acc : 0];
      in_pc     = 32'h300 + 32'(acc * 4);
      out_ready = (c >= 5);
      #1;
      if (c == 2) begin
        chk("stall in_ready", {63'b0, in_ready}, 64'd0);
        chk("stall accepted", 64'(acc), 64'd2);
      end
      if (c >= 2 && c <= 4) begin
        chk($sformatf("stall hold valid c%0d", c), {63'b0, out_valid}, 64'd1);
        chk($sformatf("stall hold imm c%0d", c), {32'b0, out_imm}, 64'hFFFFFFFF);
      end
      if (out_valid && out_ready) begin
        if (got < 4) outs[got] = out_imm;
        got++;
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("stream count", 64'(got), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("stream order %0d", k), {32'b0, outs[k]}, {32'b0, s_imm[k]});

    // Flush with both stages full and an instruction presented
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h400;
    tick();
    in_instr = 32'h01F09093; in_pc = 32'h404;
    tick();
    in_instr = 32'h123452B7; in_pc = 32'h408;
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush cycle in_ready", {63'b0, in_ready}, 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush in_ready", {63'b0, in_ready}, 64'd1);
    tick();
    chk("flush not accepted", {63'b0, out_valid}, 64'd0);

    // Reset asserted mid-stream
    in_valid = 1'b1; in_instr = 32'h0080006F; in_pc = 32'h500;
    tick();
    in_instr = 32'hFE000EE3; in_pc = 32'h504;
    tick();
    chk("pre-rst valid", {63'b0, out_valid}, 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst out_imm", {32'b0, out_imm}, 64'd0);
    chk("midrst out_extop", {58'b0, out_extop}, 64'd0);
    chk("midrst out_pc", {32'b0, out_pc}, 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post-rst quiet %0d", c), {63'b0, out_valid}, 64'd0);
    end
    chk("post-rst in_ready", {63'b0, in_ready}, 64'd1);

    // DROP_ILLEGAL=1 instance consumes the illegal word silently
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h5C;
    #1;
    chk("drop in_ready", {63'b0, d_in_ready}, 64'd1);
    tick();
    in_instr = 32'hFFF00093; in_pc = 32'h60;
    tick();
    in_valid = 1'b0;
    chk("keep illegal valid", {63'b0, out_valid}, 64'd1);
    chk("keep illegal flag", {63'b0, out_illegal}, 64'd1);
    dcnt = 0; dpc = '0;
    for (int c = 0; c < 4; c++) begin
      if (d_out_valid) begin
        dcnt++;
        dpc = d_out_pc;
        chk("drop legal imm", {32'b0, d_out_imm}, 64'hFFFFFFFF);
        chk("drop legal extop", {58'b0, d_out_extop}, 64'h10);
        chk("drop legal illegal", {63'b0, d_out_illegal}, 64'd0);
`ifdef IMM_TARGET_EN
        chk("drop legal target", {32'b0, d_out_target}, 64'h60);
`endif
      end
      tick();
    end
    chk("drop valid count", 64'(dcnt), 64'd1);
    chk("drop delivered pc", {32'b0, dpc}, 64'h60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
